// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory / MMIO responder: I/O page offsets,
// register bit positions and reset values.
package dmem_mmio_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF0000;

  localparam logic [7:0] OFF_TCNT   = 8'h00;
  localparam logic [7:0] OFF_TCMP   = 8'h04;
  localparam logic [7:0] OFF_TCTRL  = 8'h08;
  localparam logic [7:0] OFF_TXDATA = 8'h0C;
  localparam logic [7:0] OFF_TXSTAT = 8'h10;
  localparam logic [7:0] OFF_GPIO   = 8'h14;

  localparam int TCTRL_EN      = 0;
  localparam int TCTRL_AUTOCLR = 1;
  localparam int TCTRL_MATCH   = 2;

  localparam int TXSTAT_FULL  = 0;
  localparam int TXSTAT_EMPTY = 1;
  localparam int TXSTAT_OVF   = 2;

  localparam logic [31:0] TCMP_RESET = 32'hFFFFFFFF;

endpackage

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Byte-wide circular transmit FIFO with occupancy count; storage is not reset,
// only pointers and count, so the head reads 0 whenever the FIFO is empty.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder for the MIPS core: local word RAM plus an I/O page
// holding a timer, a GPIO register and a transmit FIFO. Reads are combinational.
module dmem_mmio_responder
  import dmem_mmio_responder_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] gpio_out,
  output logic        timer_irq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0] ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic        ram_sel;
  logic        io_sel;
  logic [7:0]  io_off;
  logic        wr_io;

  logic [31:0] tcnt;
  logic [31:0] tcmp;
  logic        en;
  logic        autoclr;
  logic        match;
  logic        hit;
  logic [31:0] gpio;
  logic        overflow;

  logic        push_req;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic [7:0]  txstat;

  assign ram_sel  = (memaddr < RAM_BYTES);
  assign io_sel   = (memaddr[31:8] == MMIO_BASE[31:8]);
  assign ram_idx  = memaddr[AW+1:2];
  assign io_off   = {memaddr[7:2], 2'b00};
  assign wr_io    = memwrite && io_sel;
  assign push_req = wr_io && (io_off == OFF_TXDATA);
  assign hit      = en && (tcnt == tcmp);
  assign txstat   = {4'(fifo_count), 1'b0, overflow, fifo_empty, fifo_full};

  assign tx_valid  = !fifo_empty;
  assign tx_data   = fifo_head;
  assign gpio_out  = gpio;
  assign timer_irq = match;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (memwritedata[7:0]),
    .pop       (tx_valid && tx_ready),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    memreaddata = '0;
    if (ram_sel) begin
      memreaddata = ram[ram_idx];
    end else if (io_sel) begin
      case (io_off)
        OFF_TCNT:   memreaddata = tcnt;
        OFF_TCMP:   memreaddata = tcmp;
        OFF_TCTRL:  memreaddata = {29'b0, match, autoclr, en};
        OFF_TXSTAT: memreaddata = {24'b0, txstat};
        OFF_GPIO:   memreaddata = gpio;
        default:    memreaddata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (memwrite && ram_sel) ram[ram_idx] <= memwritedata;
  end

  // CPU writes to TCNT beat the counter; a fresh match beats a MATCH clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt     <= '0;
      tcmp     <= TCMP_RESET;
      en       <= 1'b0;
      autoclr  <= 1'b0;
      match    <= 1'b0;
      gpio     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_io && io_off == OFF_TCNT) tcnt <= memwritedata;
      else if (en)                     tcnt <= (hit && autoclr) ? '0 : tcnt + 32'd1;

      if (wr_io && io_off == OFF_TCMP) tcmp <= memwritedata;

      if (wr_io && io_off == OFF_TCTRL) begin
        en      <= memwritedata[TCTRL_EN];
        autoclr <= memwritedata[TCTRL_AUTOCLR];
      end

      if (hit)
        match <= 1'b1;
      else if (wr_io && io_off == OFF_TCTRL && memwritedata[TCTRL_MATCH])
        match <= 1'b0;

      if (wr_io && io_off == OFF_GPIO) gpio <= memwritedata;

      if (push_req && fifo_full)
        overflow <= 1'b1;
      else if (wr_io && io_off == OFF_TXSTAT && memwritedata[TXSTAT_OVF])
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench: table of bus accesses with expected load data, plus
// hand-written timer, FIFO and asynchronous-reset sequences with a byte scoreboard.
module tb_dmem_mmio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [31:0] gpio_out;
  logic        timer_irq;

  localparam logic [31:0] A_TCNT   = 32'hFFFF0000;
  localparam logic [31:0] A_TCMP   = 32'hFFFF0004;
  localparam logic [31:0] A_TCTRL  = 32'hFFFF0008;
  localparam logic [31:0] A_TXDATA = 32'hFFFF000C;
  localparam logic [31:0] A_TXSTAT = 32'hFFFF0010;
  localparam logic [31:0] A_GPIO   = 32'hFFFF0014;

  dmem_mmio_responder #(
    .RAM_WORDS  (64),
    .FIFO_DEPTH (4),
    .MMIO_BASE  (32'hFFFF0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .gpio_out     (gpio_out),
    .timer_irq    (timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       ready_nxt = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input bit chk, input logic [31:0] exp_rd, input string name);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.chk = chk; v.exp_rd = exp_rd; v.name = name;
    vecs.push_back(v);
  endtask

  // One bus cycle: drive after the falling edge, observe before the rising edge.
  task automatic step(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bit accept;
    @(negedge clk);
    memwrite     = we;
    memaddr      = addr;
    memwritedata = wdata;
    tx_ready     = ready_nxt;
    #2;
    check("tx_valid", 32'(tx_valid), 32'(exp_q.size() != 0));
    accept = we && (addr == A_TXDATA) && (exp_q.size() < 4);
    if (tx_valid && tx_ready && exp_q.size() != 0)
      check("tx_data", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
    if (accept) exp_q.push_back(wdata[7:0]);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    step(1'b0, addr, 32'h0);
    check(name, memreaddata, exp);
  endtask

  int exp_cnt[5] = '{3, 4, 5, 0, 1};
  int exp_irq[5] = '{0, 0, 0, 1, 1};

  initial begin
    reset = 1'b1; memwrite = 1'b0; memaddr = '0; memwritedata = '0; tx_ready = 1'b0;
    #12;
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h0);
    check("rst_irq", 32'(timer_irq), 32'h0);
    check("rst_gpio", gpio_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    add(1, 32'h10,       32'h11111111, 0, 32'h0,        "ram_init");
    add(1, 32'h10,       32'hDEADBEEF, 1, 32'h11111111, "store_cycle_prior");
    add(0, 32'h10,       32'h0,        1, 32'hDEADBEEF, "ram_load");
    add(0, 32'h13,       32'h0,        1, 32'hDEADBEEF, "misaligned_load");
    add(1, 32'h0,        32'hCAFEF00D, 0, 32'h0,        "ram0_init");
    add(0, 32'h1000,     32'h0,        1, 32'h0,        "unmapped_load");
    add(1, 32'h1000,     32'h12345678, 1, 32'h0,        "unmapped_store");
    add(0, 32'h0,        32'h0,        1, 32'hCAFEF00D, "ram0_unchanged");
    add(0, 32'h100,      32'h0,        1, 32'h0,        "past_ram_end");
    add(0, A_TCMP,       32'h0,        1, 32'hFFFFFFFF, "tcmp_reset");
    add(0, A_TCNT,       32'h0,        1, 32'h0,        "tcnt_reset");
    add(0, A_TCTRL,      32'h0,        1, 32'h0,        "tctrl_reset");
    add(0, A_TXSTAT,     32'h0,        1, 32'h2,        "txstat_reset");
    add(0, A_TXDATA,     32'h0,        1, 32'h0,        "txdata_reads0");
    add(1, A_GPIO,       32'hA5A5A5A5, 1, 32'h0,        "gpio_store_prior");
    add(0, A_GPIO,       32'h0,        1, 32'hA5A5A5A5, "gpio_load");
    add(1, 32'hFFFF0018, 32'h1,        1, 32'h0,        "io_hole_store");
    add(0, 32'hFFFF0018, 32'h0,        1, 32'h0,        "io_hole_load");
    add(0, 32'hFFFE0014, 32'h0,        1, 32'h0,        "near_page_unmapped");

    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk) check(vecs[i].name, memreaddata, vecs[i].exp_rd);
    end
    check("gpio_out", gpio_out, 32'hA5A5A5A5);

    // Timer: TCMP=5, enable with auto-clear starting from TCNT=3.
    step(1, A_TCNT, 32'd3);
    step(1, A_TCMP, 32'd5);
    step(1, A_TCTRL, 32'd3);
    for (int i = 0; i < 5; i++) begin
      rd_chk("tcnt_seq", A_TCNT, 32'(exp_cnt[i]));
      check("irq_seq", 32'(timer_irq), 32'(exp_irq[i]));
    end
    step(1, A_TCTRL, 32'd7);
    check("tctrl_match_set", memreaddata, 32'd7);
    rd_chk("match_cleared", A_TCTRL, 32'd3);
    check("irq_cleared", 32'(timer_irq), 32'h0);
    rd_chk("tcnt_before_match", A_TCNT, 32'd4);
    step(1, A_TCTRL, 32'd7);
    check("tctrl_pre_clear", memreaddata, 32'd3);
    rd_chk("set_beats_clear", A_TCTRL, 32'd7);
    check("irq_set_wins", 32'(timer_irq), 32'h1);
    step(1, A_TCNT, 32'h100);
    rd_chk("tcnt_write_override", A_TCNT, 32'h100);
    step(1, A_TCTRL, 32'd4);
    rd_chk("tcnt_after_disable", A_TCNT, 32'h102);
    rd_chk("tcnt_holds", A_TCNT, 32'h102);
    check("irq_off", 32'(timer_irq), 32'h0);

    // FIFO overflow, then drain in order.
    ready_nxt = 1'b0;
    for (int b = 8'h41; b <= 8'h45; b++) step(1, A_TXDATA, 32'(b));
    rd_chk("txstat_full_ovf", A_TXSTAT, 32'h45);
    check("head_stable", {24'b0, tx_data}, 32'h41);
    ready_nxt = 1'b1;
    repeat (4) step(0, A_TXSTAT, 32'h0);
    ready_nxt = 1'b0;
    rd_chk("txstat_drained", A_TXSTAT, 32'h06);
    step(1, A_TXSTAT, 32'h4);
    rd_chk("ovf_cleared", A_TXSTAT, 32'h02);

    // Push to a full FIFO while popping: push still dropped.
    for (int b = 8'h71; b <= 8'h74; b++) step(1, A_TXDATA, 32'(b));
    ready_nxt = 1'b1;
    step(1, A_TXDATA, 32'h75);
    ready_nxt = 1'b0;
    rd_chk("full_push_pop", A_TXSTAT, 32'h34);
    ready_nxt = 1'b1;
    repeat (3) step(0, A_TXSTAT, 32'h0);
    ready_nxt = 1'b0;
    step(1, A_TXSTAT, 32'h4);
    rd_chk("empty_again", A_TXSTAT, 32'h02);

    // Simultaneous push and pop at count 2.
    step(1, A_TXDATA, 32'h51);
    step(1, A_TXDATA, 32'h52);
    ready_nxt = 1'b1;
    step(1, A_TXDATA, 32'h53);
    ready_nxt = 1'b0;
    rd_chk("push_pop_count", A_TXSTAT, 32'h20);
    ready_nxt = 1'b1;
    repeat (2) step(0, A_TXSTAT, 32'h0);
    ready_nxt = 1'b0;
    rd_chk("push_pop_drained", A_TXSTAT, 32'h02);

    // Asynchronous reset with three bytes queued.
    for (int b = 8'h61; b <= 8'h63; b++) step(1, A_TXDATA, 32'(b));
    step(1, 32'h20, 32'h0BADF00D);
    rd_chk("pre_reset_count", A_TXSTAT, 32'h30);
    #1 reset = 1'b1;
    #1;
    check("async_tx_valid", 32'(tx_valid), 32'h0);
    check("async_tx_data", {24'b0, tx_data}, 32'h0);
    check("async_gpio", gpio_out, 32'h0);
    check("async_txstat", memreaddata, 32'h02);
    exp_q.delete();
    @(negedge clk);
    memaddr = A_TCNT;
    #2 check("async_tcnt", memreaddata, 32'h0);
    @(negedge clk);
    memaddr = A_TCMP;
    #2 check("async_tcmp", memreaddata, 32'hFFFFFFFF);
    @(negedge clk);
    reset = 1'b0;
    rd_chk("ram_survives_0x20", 32'h20, 32'h0BADF00D);
    rd_chk("ram_survives_0x10", 32'h10, 32'hDEADBEEF);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
